assoc_argmax_seq: RTL and testbench

- Sequential, parametrised argmax stage for the HDC associative memory. It sits after the class-score accumulators and before the inference output register.
- It accepts class similarity scores LANES per beat over a valid/ready stream and reduces them to a running best.
- After NUM_CLASSES scores have been consumed, it emits the winning class index and its score over a valid/ready result interface.
- It replaces the fixed 26-input combinational bracket with a scalable, throughput-configurable block.

---
 rtl/assoc_pkg.sv | 22 ++
 rtl/assoc_lane_max.sv | 44 ++++
 rtl/assoc_argmax_seq.sv | 145 ++++++++++++++
 tb/tb_assoc_argmax_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/assoc_pkg.sv
// Shared constants, helpers and FSM state type for the associative-memory argmax stage.
package assoc_pkg;

  localparam int ASSOC_NUM_CLASSES = 26;
  localparam int ASSOC_SCORE_W     = 13;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << result) < value) result = result + 1;
    end
    return result;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } assoc_state_t;

endpackage

// File: rtl/assoc_lane_max.sv
// Combinational LANES-input max tree with per-lane valid mask; lower lane wins ties.
// ASSOC_MARGIN_EN adds the beat's second-best score (equal scores count separately).
module assoc_lane_max
  import assoc_pkg::*;
#(
  parameter int LANES   = 2,
  parameter int SCORE_W = 13,
  parameter int LIDX_W  = (LANES > 1) ? clog2(LANES) : 1
) (
  input  logic [LANES*SCORE_W-1:0] scores,
  input  logic [LANES-1:0]         lane_valid,
  output logic [SCORE_W-1:0]       max_score,
`ifdef ASSOC_MARGIN_EN
  output logic [SCORE_W-1:0]       second_score,
`endif
  output logic [LIDX_W-1:0]        max_lane
);

  // Strict '>' while scanning upward keeps the lowest lane on equal scores.
  always_comb begin
    max_score = '0;
    max_lane  = '0;
`ifdef ASSOC_MARGIN_EN
    second_score = '0;
`endif
    for (int k = 0; k < LANES; k++) begin
      if (lane_valid[k]) begin
        if (scores[k*SCORE_W +: SCORE_W] > max_score) begin
`ifdef ASSOC_MARGIN_EN
          second_score = max_score;
`endif
          max_score = scores[k*SCORE_W +: SCORE_W];
          max_lane  = LIDX_W'(k);
        end
`ifdef ASSOC_MARGIN_EN
        else if (scores[k*SCORE_W +: SCORE_W] > second_score) begin
          second_score = scores[k*SCORE_W +: SCORE_W];
        end
`endif
      end
    end
  end

endmodule

// File: rtl/assoc_argmax_seq.sv
// Sequential argmax over NUM_CLASSES scores delivered LANES per beat; emits winning class and score.
// Optional macro ASSOC_MARGIN_EN adds runner-up score and margin outputs.
module assoc_argmax_seq
  import assoc_pkg::*;
#(
  parameter  int NUM_CLASSES = ASSOC_NUM_CLASSES,
  parameter  int SCORE_W     = ASSOC_SCORE_W,
  parameter  int LANES       = 2,
  localparam int CLASS_W     = clog2(NUM_CLASSES),
  localparam int BEATS       = (NUM_CLASSES + LANES - 1) / LANES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*SCORE_W-1:0] in_scores,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       out_class,
  output logic [SCORE_W-1:0]       out_score,
`ifdef ASSOC_MARGIN_EN
  output logic [SCORE_W-1:0]       out_second,
  output logic [SCORE_W-1:0]       out_margin,
`endif
  output logic                     busy
);

  localparam int BEAT_W = (BEATS > 1) ? clog2(BEATS) : 1;
  localparam int LIDX_W = (LANES > 1) ? clog2(LANES) : 1;

  assoc_state_t        state;
  logic [BEAT_W-1:0]   beat_cnt;
  logic                first_seen;
  logic [LANES-1:0]    lane_valid;
  logic [SCORE_W-1:0]  local_max;
  logic [LIDX_W-1:0]   local_lane;
  logic [CLASS_W-1:0]  local_class;
  logic                take_local;
  logic                last_beat;
  logic [SCORE_W-1:0]  next_best;
`ifdef ASSOC_MARGIN_EN
  logic [SCORE_W-1:0]  local_second;
  logic [SCORE_W-1:0]  next_second;
`endif

  // Lanes past the last real class only exist in the final beat; mask them out.
  always_comb begin
    lane_valid = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_valid[k] = ((int'(beat_cnt) * LANES + k) < NUM_CLASSES);
    end
  end

  assoc_lane_max #(
    .LANES   (LANES),
    .SCORE_W (SCORE_W),
    .LIDX_W  (LIDX_W)
  ) u_lane_max (
    .scores       (in_scores),
    .lane_valid   (lane_valid),
    .max_score    (local_max),
`ifdef ASSOC_MARGIN_EN
    .second_score (local_second),
`endif
    .max_lane     (local_lane)
  );

  assign local_class = CLASS_W'(int'(beat_cnt) * LANES + int'(local_lane));
  assign last_beat   = (beat_cnt == BEAT_W'(BEATS - 1));
  assign take_local  = !first_seen || (local_max > out_score);
  assign next_best   = take_local ? local_max : out_score;

`ifdef ASSOC_MARGIN_EN
  // Merge the beat's top two into the running top two; ties keep both copies.
  always_comb begin
    next_second = '0;
    if (!first_seen) begin
      next_second = local_second;
    end else if (local_max > out_score) begin
      next_second = (out_score > local_second) ? out_score : local_second;
    end else begin
      next_second = (local_max > out_second) ? local_max : out_second;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      out_class  <= '0;
      out_score  <= '0;
      beat_cnt   <= '0;
      first_seen <= 1'b0;
`ifdef ASSOC_MARGIN_EN
      out_second <= '0;
      out_margin <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= ACCUM;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            beat_cnt   <= '0;
            first_seen <= 1'b0;
          end
        end
        ACCUM: begin
          if (in_valid && in_ready) begin
            first_seen <= 1'b1;
            if (take_local) begin
              out_score <= local_max;
              out_class <= local_class;
            end
`ifdef ASSOC_MARGIN_EN
            out_second <= next_second;
            out_margin <= next_best - next_second;
`endif
            if (last_beat) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_assoc_argmax_seq.sv
// Randomised self-checking bench for assoc_argmax_seq with LANES=2 and LANES=4 instances.
// Margin outputs are checked when built with ASSOC_MARGIN_EN.
module tb_assoc_argmax_seq;

  localparam int NC = 26;
  localparam int SW = 13;
  localparam int CW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           start_s     [2];
  logic           in_valid_s  [2];
  logic           out_ready_s [2];
  logic [4*SW-1:0] in_scores_s [2];
  logic           in_ready_w  [2];
  logic           out_valid_w [2];
  logic           busy_w      [2];
  logic [CW-1:0]  out_class_w [2];
  logic [SW-1:0]  out_score_w [2];
`ifdef ASSOC_MARGIN_EN
  logic [SW-1:0]  out_second_w [2];
  logic [SW-1:0]  out_margin_w [2];
`endif

  int checks = 0;
  int errors = 0;
  int scores [NC];

  assoc_argmax_seq #(.NUM_CLASSES(NC), .SCORE_W(SW), .LANES(2)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .start     (start_s[0]),
    .in_valid  (in_valid_s[0]),
    .in_ready  (in_ready_w[0]),
    .in_scores (in_scores_s[0][2*SW-1:0]),
    .out_valid (out_valid_w[0]),
    .out_ready (out_ready_s[0]),
    .out_class (out_class_w[0]),
    .out_score (out_score_w[0]),
`ifdef ASSOC_MARGIN_EN
    .out_second(out_second_w[0]),
    .out_margin(out_margin_w[0]),
`endif
    .busy      (busy_w[0])
  );

  assoc_argmax_seq #(.NUM_CLASSES(NC), .SCORE_W(SW), .LANES(4)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start_s[1]),
    .in_valid  (in_valid_s[1]),
    .in_ready  (in_ready_w[1]),
    .in_scores (in_scores_s[1]),
    .out_valid (out_valid_w[1]),
    .out_ready (out_ready_s[1]),
    .out_class (out_class_w[1]),
    .out_score (out_score_w[1]),
`ifdef ASSOC_MARGIN_EN
    .out_second(out_second_w[1]),
    .out_margin(out_margin_w[1]),
`endif
    .busy      (busy_w[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  // Reference: first index holding the maximum, and the second entry of the descending sort.
  task automatic computeExpected(output int exp_class, output int exp_score, output int exp_second);
    int q[$];
    for (int i = 0; i < NC; i++) q.push_back(scores[i]);
    q.rsort();
    exp_score  = q[0];
    exp_second = q[1];
    exp_class  = -1;
    for (int i = NC - 1; i >= 0; i--) begin
      if (scores[i] == exp_score) exp_class = i;
    end
  endtask

  task automatic checkIdle(input int sel, input string tag);
    checkOutput({tag, "_valid"}, 32'(out_valid_w[sel]), 0);
    checkOutput({tag, "_busy"}, 32'(busy_w[sel]), 0);
    checkOutput({tag, "_ready"}, 32'(in_ready_w[sel]), 0);
  endtask

  task automatic applyStimulus(input int sel, input int gap_max, input int hold,
                               input int pad_val, input bit start_at_handshake);
    int lanes;
    int beats;
    int ec, es, e2;
    lanes = (sel == 0) ? 2 : 4;
    beats = (NC + lanes - 1) / lanes;
    computeExpected(ec, es, e2);
    @(negedge clk);
    start_s[sel] = 1'b1;
    @(negedge clk);
    start_s[sel] = 1'b0;
    checkOutput("ready_accum", 32'(in_ready_w[sel]), 1);
    checkOutput("busy_accum", 32'(busy_w[sel]), 1);
    for (int b = 0; b < beats; b++) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_valid_s[sel]  = 1'b0;
        in_scores_s[sel] = {$urandom, $urandom};
        start_s[sel]     = 1'($urandom_range(0, 1));
        @(negedge clk);
        start_s[sel] = 1'b0;
      end
      in_scores_s[sel] = '0;
      for (int k = 0; k < lanes; k++) begin
        if (b * lanes + k < NC) in_scores_s[sel][k*SW +: SW] = SW'(scores[b*lanes+k]);
        else                    in_scores_s[sel][k*SW +: SW] = SW'(pad_val);
      end
      in_valid_s[sel] = 1'b1;
      checkOutput("no_early_valid", 32'(out_valid_w[sel]), 0);
      @(negedge clk);
    end
    in_valid_s[sel] = 1'b0;
    checkOutput("valid_latency", 32'(out_valid_w[sel]), 1);
    checkOutput("out_class", 32'(out_class_w[sel]), ec);
    checkOutput("out_score", 32'(out_score_w[sel]), es);
`ifdef ASSOC_MARGIN_EN
    checkOutput("out_second", 32'(out_second_w[sel]), e2);
    checkOutput("out_margin", 32'(out_margin_w[sel]), es - e2);
`endif
    repeat (hold) begin
      @(negedge clk);
      checkOutput("hold_valid", 32'(out_valid_w[sel]), 1);
      checkOutput("hold_ready", 32'(in_ready_w[sel]), 0);
      checkOutput("hold_class", 32'(out_class_w[sel]), ec);
      checkOutput("hold_score", 32'(out_score_w[sel]), es);
    end
    out_ready_s[sel] = 1'b1;
    start_s[sel]     = start_at_handshake;
    @(negedge clk);
    out_ready_s[sel] = 1'b0;
    start_s[sel]     = 1'b0;
    checkIdle(sel, "post_handshake");
  endtask

  task automatic fillScores(input int lo, input int hi);
    for (int i = 0; i < NC; i++) scores[i] = $urandom_range(lo, hi);
  endtask

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      start_s[s] = 1'b0;
      in_valid_s[s] = 1'b0;
      out_ready_s[s] = 1'b0;
      in_scores_s[s] = '0;
    end
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checkIdle(s, "reset");
      checkOutput("reset_class", 32'(out_class_w[s]), 0);
      checkOutput("reset_score", 32'(out_score_w[s]), 0);
    end
    rst = 1'b0;

    $display("[TB] ascending scores");
    for (int i = 0; i < NC; i++) scores[i] = i;
    applyStimulus(0, 0, 0, 0, 1'b0);

    $display("[TB] all equal scores");
    for (int i = 0; i < NC; i++) scores[i] = 100;
    applyStimulus(0, 0, 0, 0, 1'b0);
    applyStimulus(1, 0, 0, 0, 1'b0);

    $display("[TB] padding lanes at full scale");
    fillScores(0, 8190);
    scores[25] = 8191;
    applyStimulus(1, 0, 0, 8191, 1'b0);
    fillScores(0, 8190);
    applyStimulus(1, 1, 0, 8191, 1'b0);

    $display("[TB] input gaps and output backpressure");
    fillScores(0, 8191);
    applyStimulus(0, 3, 5, 0, 1'b1);

    $display("[TB] reset mid-query");
    @(negedge clk);
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    for (int b = 0; b < 5; b++) begin
      in_scores_s[0] = {$urandom, $urandom};
      in_valid_s[0]  = 1'b1;
      @(negedge clk);
    end
    in_valid_s[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkIdle(0, "abort");
    checkOutput("abort_class", 32'(out_class_w[0]), 0);
    checkOutput("abort_score", 32'(out_score_w[0]), 0);
    for (int i = 0; i < NC; i++) scores[i] = 10;
    scores[3] = 500;
    applyStimulus(0, 0, 0, 0, 1'b0);

    $display("[TB] runner-up and margin");
    for (int i = 0; i < NC; i++) scores[i] = 100;
    scores[7]  = 900;
    scores[12] = 850;
    applyStimulus(0, 0, 0, 0, 1'b0);
    applyStimulus(1, 0, 0, 0, 1'b0);
    scores[12] = 900;
    applyStimulus(0, 0, 0, 0, 1'b0);
    applyStimulus(1, 0, 0, 0, 1'b0);

    $display("[TB] random queries");
    for (int n = 0; n < 12; n++) begin
      if (n % 3 == 0) fillScores(0, 7);
      else            fillScores(0, 8191);
      applyStimulus(n % 2, $urandom_range(0, 2), $urandom_range(0, 3),
                    $urandom_range(0, 8191), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
